// File: rtl/mem_lsu_stage.sv
`default_nettype none
// =============================================================================
// Module  : mem_lsu_stage
// Brief   : Load/store stage between EX and WB; optional MEM_LSU_TIMEOUT_EN.
// Rev     : 1.0  initial release
// =============================================================================
module mem_lsu_stage #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_read,
    input  logic              in_write,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    input  logic [4:0]        in_rd,
    input  logic              flush,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN/8-1:0] dmem_wmask,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_resp,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_data,
    output logic [1:0]        out_err
);

    localparam int c_nbytes = XLEN / 8;
    localparam int c_offw   = $clog2(c_nbytes);

    localparam logic [1:0] c_err_ok      = 2'b00;
    localparam logic [1:0] c_err_align   = 2'b01;
    localparam logic [1:0] c_err_width   = 2'b10;
    localparam logic [1:0] c_err_timeout = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BUSY  = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    generate
        if ((XLEN != 32 && XLEN != 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
            $error("mem_lsu_stage: unsupported XLEN or TIMEOUT_CYCLES");
        end
    endgenerate

    state_t              r_state;
    logic [c_offw-1:0]   r_off;
    logic [1:0]          r_size;
    logic                r_uns;

    logic                w_accept;
    logic                w_mem;
    logic                w_illegal;
    logic                w_misaligned;
    logic [c_offw-1:0]   w_off;
    logic [3:0]          w_size_m1;
    logic [7:0]          w_mask_base;
    logic [c_nbytes-1:0] w_wmask;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_shift;
    logic [XLEN-1:0]     w_ld_word;
    logic [XLEN-1:0]     w_ld_data;
    logic                w_expire;

    assign in_ready  = (r_state == ST_IDLE);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign w_mem     = in_read | in_write;
    assign w_off     = in_addr[c_offw-1:0];
    assign w_size_m1 = (4'd1 << in_funct3[1:0]) - 4'd1;

    // Doubleword accesses only exist on a 64-bit datapath; stores have no unsigned form.
    assign w_illegal    = (in_funct3 == 3'b111)
                        | (in_write & in_funct3[2])
                        | ((XLEN == 32) & (in_funct3[1:0] == 2'b11));
    assign w_misaligned = |(w_off & w_size_m1[c_offw-1:0]);

    always_comb begin
        w_mask_base = 8'hFF;
        case (in_funct3[1:0])
            2'd0:    w_mask_base = 8'h01;
            2'd1:    w_mask_base = 8'h03;
            2'd2:    w_mask_base = 8'h0F;
            default: w_mask_base = 8'hFF;
        endcase
    end

    assign w_wmask = w_mask_base[c_nbytes-1:0] << w_off;
    assign w_wdata = in_wdata << {w_off, 3'b000};

    assign w_shift = dmem_rdata >> {r_off, 3'b000};

    generate
        if (XLEN > 32) begin : g_word_ext
            assign w_ld_word = {{(XLEN-32){~r_uns & w_shift[31]}}, w_shift[31:0]};
        end else begin : g_word_full
            assign w_ld_word = w_shift;
        end
    endgenerate

    always_comb begin
        w_ld_data = w_shift;
        case (r_size)
            2'd0:    w_ld_data = {{(XLEN-8){~r_uns & w_shift[7]}}, w_shift[7:0]};
            2'd1:    w_ld_data = {{(XLEN-16){~r_uns & w_shift[15]}}, w_shift[15:0]};
            2'd2:    w_ld_data = w_ld_word;
            default: w_ld_data = w_shift;
        endcase
    end

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_tw-1:0] r_timer;

    // Counts completed BUSY/DRAIN cycles; restarts on entry to either state.
    assign w_expire = (r_timer == c_tw'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (r_state == ST_IDLE || (r_state == ST_BUSY && flush)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_off      <= '0;
            r_size     <= '0;
            r_uns      <= 1'b0;
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            dmem_addr  <= '0;
            dmem_wmask <= '0;
            dmem_wdata <= '0;
            out_valid  <= 1'b0;
            out_rd     <= '0;
            out_data   <= '0;
            out_err    <= c_err_ok;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        out_rd <= in_rd;
                        if (!w_mem) begin
                            out_valid <= 1'b1;
                            out_data  <= in_addr;
                            out_err   <= c_err_ok;
                        end else if (w_illegal) begin
                            out_valid <= 1'b1;
                            out_data  <= in_addr;
                            out_err   <= c_err_width;
                        end else if (w_misaligned) begin
                            out_valid <= 1'b1;
                            out_data  <= in_addr;
                            out_err   <= c_err_align;
                        end else begin
                            r_state    <= ST_BUSY;
                            r_off      <= w_off;
                            r_size     <= in_funct3[1:0];
                            r_uns      <= in_funct3[2];
                            dmem_read  <= in_read;
                            dmem_write <= in_write;
                            dmem_addr  <= {in_addr[XLEN-1:c_offw], {c_offw{1'b0}}};
                            dmem_wmask <= in_write ? w_wmask : '0;
                            dmem_wdata <= in_write ? w_wdata : '0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (flush) begin
                        if (dmem_resp) begin
                            r_state    <= ST_IDLE;
                            dmem_read  <= 1'b0;
                            dmem_write <= 1'b0;
                            dmem_wmask <= '0;
                        end else begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (dmem_resp) begin
                        r_state    <= ST_IDLE;
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        dmem_wmask <= '0;
                        out_valid  <= 1'b1;
                        out_data   <= dmem_read ? w_ld_data : '0;
                        out_err    <= c_err_ok;
                    end else if (w_expire) begin
                        r_state    <= ST_IDLE;
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        dmem_wmask <= '0;
                        out_valid  <= 1'b1;
                        // Aligned base plus the stored offset rebuilds the original address.
                        out_data   <= {dmem_addr[XLEN-1:c_offw], r_off};
                        out_err    <= c_err_timeout;
                    end
                end
                ST_DRAIN: begin
                    if (dmem_resp || w_expire) begin
                        r_state    <= ST_IDLE;
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        dmem_wmask <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    dmem_read  <= 1'b0;
                    dmem_write <= 1'b0;
                    dmem_wmask <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu_stage.sv
`default_nettype none
// =============================================================================
// Module  : tb_mem_lsu_stage
// Brief   : Scoreboard bench for mem_lsu_stage (XLEN=32 and XLEN=64 instances).
// Rev     : 1.0  initial release
// =============================================================================
module tb_mem_lsu_stage;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
        logic [1:0]  err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q0[$];
    exp_t q1[$];

    logic        in_valid[2], in_read[2], in_write[2], flush[2], dmem_resp[2];
    logic [2:0]  in_funct3[2];
    logic [63:0] in_addr[2], in_wdata[2], dmem_rdata[2];
    logic [4:0]  in_rd[2];

    logic        in_ready[2], dmem_read[2], dmem_write[2], out_valid[2];
    logic [63:0] dmem_addr[2], dmem_wdata[2], out_data[2];
    logic [7:0]  dmem_wmask[2];
    logic [4:0]  out_rd[2];
    logic [1:0]  out_err[2];

    logic        a_in_ready, a_dmem_read, a_dmem_write, a_out_valid;
    logic [31:0] a_dmem_addr, a_dmem_wdata, a_out_data;
    logic [3:0]  a_dmem_wmask;
    logic [4:0]  a_out_rd;
    logic [1:0]  a_out_err;
    logic        b_in_ready, b_dmem_read, b_dmem_write, b_out_valid;
    logic [63:0] b_dmem_addr, b_dmem_wdata, b_out_data;
    logic [7:0]  b_dmem_wmask;
    logic [4:0]  b_out_rd;
    logic [1:0]  b_out_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_lsu_stage #(.XLEN(32), .TIMEOUT_CYCLES(8)) u_dut32 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[0]), .in_ready(a_in_ready),
        .in_read(in_read[0]), .in_write(in_write[0]), .in_funct3(in_funct3[0]),
        .in_addr(in_addr[0][31:0]), .in_wdata(in_wdata[0][31:0]), .in_rd(in_rd[0]),
        .flush(flush[0]),
        .dmem_read(a_dmem_read), .dmem_write(a_dmem_write), .dmem_addr(a_dmem_addr),
        .dmem_wmask(a_dmem_wmask), .dmem_wdata(a_dmem_wdata),
        .dmem_resp(dmem_resp[0]), .dmem_rdata(dmem_rdata[0][31:0]),
        .out_valid(a_out_valid), .out_rd(a_out_rd), .out_data(a_out_data), .out_err(a_out_err)
    );

    mem_lsu_stage #(.XLEN(64), .TIMEOUT_CYCLES(8)) u_dut64 (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid[1]), .in_ready(b_in_ready),
        .in_read(in_read[1]), .in_write(in_write[1]), .in_funct3(in_funct3[1]),
        .in_addr(in_addr[1]), .in_wdata(in_wdata[1]), .in_rd(in_rd[1]),
        .flush(flush[1]),
        .dmem_read(b_dmem_read), .dmem_write(b_dmem_write), .dmem_addr(b_dmem_addr),
        .dmem_wmask(b_dmem_wmask), .dmem_wdata(b_dmem_wdata),
        .dmem_resp(dmem_resp[1]), .dmem_rdata(dmem_rdata[1]),
        .out_valid(b_out_valid), .out_rd(b_out_rd), .out_data(b_out_data), .out_err(b_out_err)
    );

    assign in_ready[0] = a_in_ready;     assign in_ready[1] = b_in_ready;
    assign dmem_read[0] = a_dmem_read;   assign dmem_read[1] = b_dmem_read;
    assign dmem_write[0] = a_dmem_write; assign dmem_write[1] = b_dmem_write;
    assign out_valid[0] = a_out_valid;   assign out_valid[1] = b_out_valid;
    assign dmem_addr[0] = {32'h0, a_dmem_addr};   assign dmem_addr[1] = b_dmem_addr;
    assign dmem_wdata[0] = {32'h0, a_dmem_wdata}; assign dmem_wdata[1] = b_dmem_wdata;
    assign out_data[0] = {32'h0, a_out_data};     assign out_data[1] = b_out_data;
    assign dmem_wmask[0] = {4'h0, a_dmem_wmask};  assign dmem_wmask[1] = b_dmem_wmask;
    assign out_rd[0] = a_out_rd;   assign out_rd[1] = b_out_rd;
    assign out_err[0] = a_out_err; assign out_err[1] = b_out_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int s, input logic [4:0] rd, input logic [63:0] data,
                        input logic [1:0] err, input int at);
        exp_t e;
        e.rd = rd; e.data = data; e.err = err; e.cyc = at;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int s);
        exp_t e;
        if (!out_valid[s]) return;
        if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
            check($sformatf("dut%0d_unexpected_out_valid", s), 64'd1, 64'd0);
            return;
        end
        if (s == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("dut%0d_out_data", s), out_data[s], e.data);
        check($sformatf("dut%0d_out_err", s), 64'(out_err[s]), 64'(e.err));
        check($sformatf("dut%0d_out_rd", s), 64'(out_rd[s]), 64'(e.rd));
        check($sformatf("dut%0d_out_cycle", s), 64'(cyc), 64'(e.cyc));
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            mon(0);
            mon(1);
        end
    end

    task automatic issue(input int s, input logic rd_op, input logic wr_op, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                         output int acc);
        int n;
        n = 0;
        while (!in_ready[s] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("dut%0d_ready_before_issue", s), 64'(in_ready[s]), 64'd1);
        in_valid[s] = 1'b1; in_read[s] = rd_op; in_write[s] = wr_op; in_funct3[s] = f3;
        in_addr[s] = addr; in_wdata[s] = wdata; in_rd[s] = rd;
        acc = cyc;
        @(posedge clk); #1;
        in_valid[s] = 1'b0; in_read[s] = 1'b0; in_write[s] = 1'b0;
    endtask

    task automatic check_req(input int s, input string name, input logic rd_op, input logic wr_op,
                             input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] wdata);
        check({name, "_ctrl"}, 64'({dmem_read[s], dmem_write[s], dmem_wmask[s]}), 64'({rd_op, wr_op, mask}));
        check({name, "_addr"}, dmem_addr[s], addr);
        check({name, "_wdata"}, dmem_wdata[s], wdata);
    endtask

    task automatic mem_op(input int s, input string name, input logic rd_op, input logic wr_op,
                          input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [4:0] rd, input int waits, input logic [63:0] rdata,
                          input logic [63:0] e_addr, input logic [7:0] e_mask,
                          input logic [63:0] e_wdata, input logic [63:0] e_data);
        int acc;
        issue(s, rd_op, wr_op, f3, addr, wdata, rd, acc);
        push(s, rd, e_data, 2'b00, acc + 2 + waits);
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin
                dmem_resp[s] = 1'b1;
                dmem_rdata[s] = rdata;
            end
            @(negedge clk);
            check_req(s, name, rd_op, wr_op, e_addr, e_mask, e_wdata);
            @(posedge clk); #1;
            dmem_resp[s] = 1'b0;
        end
        @(negedge clk);
        check({name, "_released"}, 64'({dmem_read[s], dmem_write[s]}), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic err_op(input int s, input string name, input logic rd_op, input logic wr_op,
                          input logic [2:0] f3, input logic [63:0] addr, input logic [4:0] rd,
                          input logic [1:0] e_err);
        int acc;
        issue(s, rd_op, wr_op, f3, addr, 64'hFFFF_FFFF, rd, acc);
        push(s, rd, addr, e_err, acc + 1);
        @(negedge clk);
        check({name, "_no_access"}, 64'({dmem_read[s], dmem_write[s]}), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        reset_n = 1'b0;
        for (int s = 0; s < 2; s++) begin
            in_valid[s] = 0; in_read[s] = 0; in_write[s] = 0; flush[s] = 0; dmem_resp[s] = 0;
            in_funct3[s] = 0; in_addr[s] = 0; in_wdata[s] = 0; dmem_rdata[s] = 0; in_rd[s] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check($sformatf("dut%0d_reset_ready", s), 64'(in_ready[s]), 64'd1);
            check($sformatf("dut%0d_reset_ctrl", s),
                  64'({out_valid[s], dmem_read[s], dmem_write[s], dmem_wmask[s], out_err[s], out_rd[s]}), 64'd0);
            check($sformatf("dut%0d_reset_data", s), out_data[s] | dmem_addr[s] | dmem_wdata[s], 64'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back ALU pass-through results
        issue(0, 0, 0, 3'b000, 64'h1234_5678, 0, 5'd3, acc);
        push(0, 5'd3, 64'h1234_5678, 2'b00, acc + 1);
        issue(0, 0, 0, 3'b010, 64'h0000_CAFE, 0, 5'd4, acc);
        push(0, 5'd4, 64'h0000_CAFE, 2'b00, acc + 1);

        mem_op(0, "lbu", 1, 0, 3'b100, 64'h1003, 0, 5'd5, 3, 64'h80FF_0000,
               64'h1000, 8'h0, 64'h0, 64'h0000_0080);
        mem_op(0, "lb", 1, 0, 3'b000, 64'h1003, 0, 5'd5, 0, 64'h80FF_0000,
               64'h1000, 8'h0, 64'h0, 64'hFFFF_FF80);
        mem_op(0, "sh", 0, 1, 3'b001, 64'h2002, 64'h0000_BEEF, 5'd6, 2, 64'h0,
               64'h2000, 8'hC, 64'hBEEF_0000, 64'h0);
        mem_op(0, "sb", 0, 1, 3'b000, 64'h2001, 64'h1234_5678, 5'd7, 1, 64'h0,
               64'h2000, 8'h2, 64'h3456_7800, 64'h0);
        mem_op(0, "lh", 1, 0, 3'b001, 64'h3002, 0, 5'd8, 0, 64'hABCD_1234,
               64'h3000, 8'h0, 64'h0, 64'hFFFF_ABCD);
        mem_op(0, "lw", 1, 0, 3'b010, 64'h4000, 0, 5'd10, 1, 64'hDEAD_BEEF,
               64'h4000, 8'h0, 64'h0, 64'hDEAD_BEEF);

        err_op(0, "lw_misaligned", 1, 0, 3'b010, 64'h3001, 5'd12, 2'b01);
        err_op(0, "ld_on_rv32", 1, 0, 3'b011, 64'h3000, 5'd13, 2'b10);
        err_op(0, "load_f3_111", 1, 0, 3'b111, 64'h3000, 5'd14, 2'b10);
        err_op(0, "store_unsigned", 0, 1, 3'b100, 64'h3000, 5'd15, 2'b10);
        err_op(0, "sw_misaligned", 0, 1, 3'b010, 64'h3002, 5'd16, 2'b01);

        // Flush one cycle after accept: request held through drain, no result
        issue(0, 1, 0, 3'b001, 64'h4002, 0, 5'd11, acc);
        flush[0] = 1'b1;
        @(negedge clk);
        check_req(0, "flush_busy", 1, 0, 64'h4000, 8'h0, 64'h0);
        @(posedge clk); #1;
        flush[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_req(0, "flush_drain", 1, 0, 64'h4000, 8'h0, 64'h0);
            check("flush_drain_ready", 64'(in_ready[0]), 64'd0);
            @(posedge clk); #1;
        end
        dmem_resp[0] = 1'b1; dmem_rdata[0] = 64'h1234_5678;
        @(negedge clk);
        check_req(0, "flush_resp", 1, 0, 64'h4000, 8'h0, 64'h0);
        @(posedge clk); #1;
        dmem_resp[0] = 1'b0;
        @(negedge clk);
        check("flush_ready_back", 64'(in_ready[0]), 64'd1);
        check("flush_read_drop", 64'(dmem_read[0]), 64'd0);
        @(posedge clk); #1;

        // Flush while idle blocks capture
        in_valid[0] = 1; in_read[0] = 1; in_funct3[0] = 3'b010; in_addr[0] = 64'h5000; flush[0] = 1;
        @(posedge clk); #1;
        in_valid[0] = 0; in_read[0] = 0; flush[0] = 0;
        @(negedge clk);
        check("flush_idle_no_req", 64'({dmem_read[0], out_valid[0]}), 64'd0);
        check("flush_idle_ready", 64'(in_ready[0]), 64'd1);
        @(posedge clk); #1;

        // Stray response while idle
        dmem_resp[0] = 1'b1;
        @(posedge clk); #1;
        dmem_resp[0] = 1'b0;
        @(negedge clk);
        check("idle_resp_ignored", 64'(out_valid[0]), 64'd0);
        @(posedge clk); #1;

        // Unanswered request
        issue(0, 1, 0, 3'b010, 64'h6000, 0, 5'd9, acc);
`ifdef MEM_LSU_TIMEOUT_EN
        push(0, 5'd9, 64'h6000, 2'b11, acc + 9);
        repeat (12) @(posedge clk);
        #1;
        check("timeout_ready", 64'(in_ready[0]), 64'd1);
`else
        repeat (20) @(posedge clk);
        #1;
        check("no_timeout_busy", 64'({in_ready[0], dmem_read[0]}), 64'b01);
        dmem_resp[0] = 1'b1; dmem_rdata[0] = 64'h0BAD_F00D;
        push(0, 5'd9, 64'h0BAD_F00D, 2'b00, cyc + 1);
        @(posedge clk); #1;
        dmem_resp[0] = 1'b0;
`endif
        @(posedge clk); #1;

        // 64-bit datapath
        mem_op(1, "rv64_lw", 1, 0, 3'b010, 64'h0000_0001_0000_000C, 0, 5'd20, 1,
               64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0008, 8'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
        mem_op(1, "rv64_ld", 1, 0, 3'b011, 64'h0000_0001_0000_0008, 0, 5'd21, 0,
               64'h0123_4567_89AB_CDEF, 64'h0000_0001_0000_0008, 8'h0, 64'h0, 64'h0123_4567_89AB_CDEF);
        mem_op(1, "rv64_lwu", 1, 0, 3'b110, 64'h0000_0000_0000_0004, 0, 5'd22, 0,
               64'h8000_0000_0000_0000, 64'h0, 8'h0, 64'h0, 64'h0000_0000_8000_0000);
        mem_op(1, "rv64_sw", 0, 1, 3'b010, 64'h0000_0000_0000_0104, 64'h1122_3344, 5'd23, 2,
               64'h0, 64'h0000_0000_0000_0100, 8'hF0, 64'h1122_3344_0000_0000, 64'h0);
        err_op(1, "rv64_ld_misaligned", 1, 0, 3'b011, 64'h0000_0000_0000_0204, 5'd24, 2'b01);

        // Reset asserted mid-request
        issue(1, 1, 0, 3'b011, 64'h0000_0000_0000_0300, 0, 5'd25, acc);
        check("rst_busy_read", 64'(dmem_read[1]), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_async_read", 64'(dmem_read[1]), 64'd0);
        check("rst_async_ready", 64'(in_ready[1]), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        dmem_resp[1] = 1'b1; dmem_rdata[1] = 64'hFFFF_0000_FFFF_0000;
        @(posedge clk); #1;
        dmem_resp[1] = 1'b0;
        @(negedge clk);
        check("rst_late_resp_ignored", 64'({out_valid[1], in_ready[1]}), 64'b01);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
Parametrised load/store memory stage for the rv32i pipeline, sitting between EX and WB. It accepts one operation per handshake and drives a held-until-response data-memory request. It generates byte-lane store masks, aligns and extends load data, and detects misaligned or illegal accesses. It also handles flushes from branch mispredicts by draining an in-flight request without retiring it.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TIMEOUT_CYCLES, 1024, BUSY cycles before an abandoned request; used only with MEM_LSU_TIMEOUT_EN.

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  EX presents an operation
in_ready  output  1  stage can accept; 0 = stall upstream
in_read  input  1  load op
in_write  input  1  store op; in_read and in_write are never both 1
in_funct3  input  3  RISC-V load/store funct3
in_addr  input  XLEN  effective address, or ALU result for non-memory ops
in_wdata  input  XLEN  store data, already forwarded
in_rd  input  5  destination register
flush  input  1  kill the operation in this stage
dmem_read  output  1  memory read request
dmem_write  output  1  memory write request
dmem_addr  output  XLEN  address aligned down to XLEN/8 bytes
dmem_wmask  output  XLEN/8  byte-lane write enables
dmem_wdata  output  XLEN  lane-shifted store data
dmem_resp  input  1  memory completion, one-cycle pulse
dmem_rdata  input  XLEN  read data, valid with dmem_resp
out_valid  output  1  one-cycle result pulse to WB
out_rd  output  5  destination register of the result
out_data  output  XLEN  load result, ALU pass-through, or fault address
out_err  output  2  00 ok, 01 misaligned, 10 illegal width, 11 timeout

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - All outputs are 0, except in_ready, which is 1.
  - A request in flight is abandoned; a dmem_resp arriving after reset is ignored.
- Accept condition: in_valid & in_ready & ~flush. in_ready = (state==IDLE).
- Non-memory op (in_read=in_write=0):
  - out_valid is asserted the next cycle.
  - out_data = in_addr, out_err = 00.
- Width decode: funct3[1:0] selects 1/2/4/8 bytes; funct3[2] selects zero-extend for loads.
- Illegal width, reported as err 10 with no memory access:
  - size 8 when XLEN=32;
  - funct3 = 111;
  - store with funct3[2]=1.
- Misalignment: addr mod size != 0 gives err 01 with no memory access.
- Error result timing: out_valid is asserted the next cycle with out_data = in_addr.
- Legal memory op: on accept, the request is registered and the state goes to BUSY.
  - dmem_read or dmem_write is asserted from the next cycle.
  - dmem_addr, dmem_wmask and dmem_wdata are held stable until dmem_resp.
- Byte offset: off = in_addr[log2(XLEN/8)-1:0].
- Store data: dmem_wmask = ((1<<size)-1) << off; dmem_wdata = in_wdata << (8*off).
- Load data: (dmem_rdata >> 8*off), truncated to size, then sign- or zero-extended to XLEN.
- Response handling: dmem_resp in BUSY in cycle M produces out_valid in cycle M+1, and the state returns to IDLE.
  - Minimum load/store latency is accept + 2 cycles.
  - dmem_resp in IDLE is ignored.
- Flush in IDLE: the input is not captured and no out_valid is produced.
- Flush in BUSY: the state goes to DRAIN.
  - The request is held until dmem_resp, then the state goes to IDLE with no out_valid.
  - A dmem_resp in the same cycle as the flush completes the drain directly to IDLE.
- Flush in DRAIN has no effect.
- Flush and out_valid: a pending out_valid register (already produced) is not cleared by flush.
- After IDLE: the cycle after returning to IDLE, in_ready=1; back-to-back accepts are allowed.
- State encoding: IDLE, BUSY and DRAIN are mutually exclusive and encoded in 2 bits; an illegal encoding recovers to IDLE.

Optional Feature:
- Macro: MEM_LSU_TIMEOUT_EN.
- When defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each BUSY/DRAIN cycle and clears on entry.
  - When it reaches TIMEOUT_CYCLES in BUSY, the request is dropped and the state goes to IDLE; out_valid follows next cycle with err 11 and out_data = request address.
  - When it reaches TIMEOUT_CYCLES in DRAIN, the state goes to IDLE silently.
  - dmem_resp in the same cycle as expiry wins, giving a normal completion.
- When not defined: no counter; the stage waits indefinitely and err 11 is never produced.

Test Plan:
- XLEN=32, LBU addr 0x1003, dmem_rdata 0x80FF_0000 after 3 wait cycles -> dmem_addr 0x1000, out_data 0x0000_0080, out_valid at accept+5.
- SH addr 0x2002, wdata 0x0000_BEEF -> dmem_wmask 1100, dmem_wdata 0xBEEF_0000, held until dmem_resp; out_err 00.
- LW addr 0x3001 -> no dmem_read ever, out_valid next cycle, out_err 01, out_data 0x3001; XLEN=32 LD -> out_err 10.
- LH accepted, flush asserted next cycle, dmem_resp 4 cycles later -> request held throughout, no out_valid, in_ready returns 1 after resp.
- XLEN=64, LW addr 0x...0C, rdata 0xFFFF_FFFF_0000_0000 -> out_data 0xFFFF_FFFF_FFFF_FFFF; reset_n low mid-BUSY -> dmem_read 0 immediately, later dmem_resp ignored.
- With MEM_LSU_TIMEOUT_EN, TIMEOUT_CYCLES=8, no dmem_resp -> after 8 BUSY cycles the request drops, out_err 11; without the macro, the stage stays BUSY.
